// File: rtl/uart_pkg.sv
// uart_pkg: shared types, widths and baud divisor helper for the UART receiver.
// Contents: uart_rx_state_e (FSM states), UART_DATA_W, uart_div().
// Macro UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;
  localparam int UART_DATA_W = 8;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;
`endif
  function automatic int uart_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with push/pop, full/empty and head data.
// Ports: clk_i, rst_ni (async active-low), push_i/data_i write side,
//        pop_i read side, data_o head byte (0 when empty), full_o, empty_o.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr      = push_i & (~full_o | pop_i);
  assign rd      = pop_i & ~empty_o;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign cnt_d   = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr ? wr_q + 1'b1 : wr_q;
      rd_q  <= rd ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i)
    if (wr) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/uart_rx_fifo_rx.sv
// uart_rx_fifo_rx: oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a receive FIFO.
// Ports: clk_i, rst_ni (async active-low), rx_i serial line (idle high),
//        data_o/valid_o/ready_i FIFO head handshake,
//        frame_err_o, overrun_o, parity_err_o one-cycle error pulses.
module uart_rx_fifo_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   parity_err_o
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  uart_rx_state_e         state_q;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   frame_err_q, overrun_q;
  logic                   full, empty, push, pop, strobe, fall;
  assign strobe  = cnt_q == '0;
  // Only a high-to-low transition starts a frame, so a held-low break after a framing error never retriggers.
  assign fall    = rx_prev_q & ~rx_s_q;
  assign pop     = ~empty & ready_i;
  assign valid_o = ~empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  logic perr_q, parity_err_q;
  assign parity_err_o = parity_err_q;
  assign push = state_q == STOP && strobe && rx_s_q && !perr_q;
`else
  assign parity_err_o = 1'b0;
  assign push = state_q == STOP && strobe && rx_s_q;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      cnt_q       <= strobe ? CNT_FULL : cnt_q - 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= push & full & ~pop;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE:
          if (fall) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
          end
        START:
          if (strobe) begin
            state_q <= rx_s_q ? IDLE : DATA;
            idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
          end
        DATA:
          if (strobe) begin
            shift_q <= {rx_s_q, shift_q[UART_DATA_W-1:1]};
            idx_q   <= idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx_q == 3'(UART_DATA_W - 1)) state_q <= PARITY;
`else
            if (idx_q == 3'(UART_DATA_W - 1)) state_q <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (strobe) begin
            perr_q       <= ^{shift_q, rx_s_q};
            parity_err_q <= ^{shift_q, rx_s_q};
            state_q      <= STOP;
          end
`endif
        STOP:
          if (strobe) begin
            frame_err_q <= ~rx_s_q;
            state_q     <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
